pacman_game_ctrl: RTL and testbench
===================================

Name: pacman_game_ctrl

Overview:
- Parametrised game-state controller for the PacMan datapath.
- Evaluates PacMan/ghost and PacMan/fruit collisions once per video frame using bounding-box overlap.
- Holds score, lives and fruit-eaten flags in registers and sequences the pause/run/death/win/lose flow.
- Sits between the sprite position logic and the HUD/colour mapper, which consume its outputs.

Parameters:
NUM_GHOSTS, 3, number of ghost sprites checked
NUM_FRUITS, 4, number of fruit pickups; win when all eaten
COORD_W, 10, width of every X/Y coordinate and size input
SCORE_W, 12, score register width
FRUIT_PTS, 50, points added per fruit eaten
START_LIVES, 3, lives loaded at reset and at new game; must be 1..7
DEATH_FRAMES, 60, frame ticks spent in DEATH before respawn

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (vsync edge); collisions are sampled only on this pulse
keycode  in  8  USB HID keycode
pX, pY  in  COORD_W each  PacMan top-left corner
pSize  in  COORD_W  PacMan edge length
gX, gY  in  NUM_GHOSTS*COORD_W each  packed ghost top-left corners; ghost i occupies bits [i*COORD_W +: COORD_W]
gSize  in  COORD_W  ghost edge length
fX, fY  in  NUM_FRUITS*COORD_W each  packed fruit top-left corners
fSize  in  COORD_W  fruit edge length
win  out  1  high while in GAME_WON
lose  out  1  high while in GAME_OVER
running  out  1  high while in RUN; gates sprite movement
fruits  out  NUM_FRUITS  bit i set means fruit i is eaten (sprite hidden)
score  out  SCORE_W  current score
lives  out  3  remaining lives
respawn  out  1  one-cycle pulse on DEATH to PAUSE; the position logic resets sprites on it

Behaviour:
- Reset is synchronous, active-high: state=PAUSE, score=0, fruits=0, lives=START_LIVES, respawn=0. All outputs are registered or decoded from the state register.
- Move key is any of 8'h04, 8'h07, 8'h16 or 8'h1A. Restart key is 8'h2C.
- Overlap(A,B) = (Ax < Bx+Bs) && (Bx < Ax+As) && (Ay < By+Bs) && (By < Ay+As).
  - Evaluate with COORD_W+1-bit sums, so there is no wrap-around.
  - Boxes that only touch edges do not collide.
- PAUSE:
  - On a move key, go to RUN on the next cycle.
  - frame_tick is ignored.
- RUN, on frame_tick only:
  - Priority 1: if any ghost overlaps PacMan, go to DEATH, decrement lives and load the frame counter with DEATH_FRAMES.
  - Priority 2, only if no ghost hit: find the lowest-index uneaten fruit that overlaps PacMan.
    - Set its fruits bit.
    - Add FRUIT_PTS to score, saturating at 2^SCORE_W-1.
    - Only one fruit is consumed per tick; others are taken on later ticks.
  - If this makes fruits all-ones, go to GAME_WON in the same update.
  - A ghost hit on the same tick suppresses the fruit, so death wins.
- DEATH:
  - Decrement the counter on each frame_tick.
  - When the counter reaches 0 and lives>0: pulse respawn for 1 cycle and go to PAUSE. Score and fruits are retained.
  - When the counter reaches 0 and lives==0: go to GAME_OVER with no respawn pulse.
- GAME_OVER / GAME_WON:
  - Hold until the restart key.
  - Then go to PAUSE, clear score and fruits, reload lives=START_LIVES and pulse respawn.
- Illegal state encodings recover to PAUSE on the next cycle.
- keycode is level-sensitive. A move key held through the DEATH to PAUSE transition resumes RUN on the following cycle, which is intended.
- Reset asserted mid-game overrides everything on that cycle.

Optional Feature:
POWER_FRUIT_EN:
- When defined, adds parameter FRIGHT_FRAMES (default 300), parameter GHOST_PTS (default 200), and output ghost_eaten [NUM_GHOSTS-1:0], a one-cycle-per-event pulse vector.
- Eating a fruit loads the fright counter with FRIGHT_FRAMES. The counter decrements per frame_tick in RUN and is held in other states.
- While the counter is nonzero, ghost overlap does not cause DEATH. Instead:
  - Every overlapping ghost pulses its ghost_eaten bit.
  - Score adds GHOST_PTS per overlapping ghost, saturating.
  - Fruit logic is still evaluated on the same tick.
- Undefined: no fright counter, no ghost_eaten port, and ghost overlap always kills.

Test Plan:
- Reset, then keycode=8'h1A -> RUN one cycle later; score=0, lives=3, fruits=4'b0000.
- RUN with PacMan at (12,10), pSize=16, fruit0 at (20,18), fSize=8, plus a frame_tick -> fruits=4'b0001, score=50. A second tick at the same position leaves score=50.
- pX=100, gX0=116, same Y, sizes 16 (edges touch), frame_tick -> no death. Then gX0=115 -> DEATH, lives=2; after 60 ticks respawn pulses and state=PAUSE.
- On one tick, ghost 1 overlaps and an uneaten fruit overlaps -> DEATH, fruit bit unchanged, score unchanged.
- With three fruits eaten, eating the last -> fruits=4'b1111, score=200, win=1. keycode=8'h2C -> PAUSE, score=0, lives=3, respawn pulses.
- Three deaths -> lose=1 after the third DEATH_FRAMES with no respawn pulse. Reset asserted while in DEATH -> PAUSE, lives=3 on the next cycle.

Source files
------------

// File: rtl/pacman_game_ctrl.sv
// pacman_game_ctrl: per-frame PacMan collision checks, score/lives registers and pause/run/death/win/lose flow.
// Optional POWER_FRUIT_EN: eating a fruit frightens ghosts so overlapping ghosts are eaten for points instead of killing.
module pacman_game_ctrl #(
  parameter int NUM_GHOSTS   = 3,
  parameter int NUM_FRUITS   = 4,
  parameter int COORD_W      = 10,
  parameter int SCORE_W      = 12,
  parameter int FRUIT_PTS    = 50,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60
`ifdef POWER_FRUIT_EN
  ,
  parameter int FRIGHT_FRAMES = 300,
  parameter int GHOST_PTS     = 200
`endif
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_tick,
  input  logic [7:0]                     keycode,
  input  logic [COORD_W-1:0]             pX,
  input  logic [COORD_W-1:0]             pY,
  input  logic [COORD_W-1:0]             pSize,
  input  logic [NUM_GHOSTS*COORD_W-1:0]  gX,
  input  logic [NUM_GHOSTS*COORD_W-1:0]  gY,
  input  logic [COORD_W-1:0]             gSize,
  input  logic [NUM_FRUITS*COORD_W-1:0]  fX,
  input  logic [NUM_FRUITS*COORD_W-1:0]  fY,
  input  logic [COORD_W-1:0]             fSize,
  output logic                           win,
  output logic                           lose,
  output logic                           running,
  output logic [NUM_FRUITS-1:0]          fruits,
  output logic [SCORE_W-1:0]             score,
  output logic [2:0]                     lives,
  output logic                           respawn
`ifdef POWER_FRUIT_EN
  ,
  output logic [NUM_GHOSTS-1:0]          ghost_eaten
`endif
);

  typedef enum logic [2:0] {
    PAUSE     = 3'd0,
    RUN       = 3'd1,
    DEATH     = 3'd2,
    GAME_OVER = 3'd3,
    GAME_WON  = 3'd4
  } state_t;

  localparam int CNT_W = (DEATH_FRAMES < 2) ? 1 : $clog2(DEATH_FRAMES + 1);
  localparam int SUM_W = SCORE_W + 16;
  localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  state_t             state;
  logic [CNT_W-1:0]   death_cnt;
  logic [NUM_GHOSTS-1:0] ghost_hit;
  logic [NUM_FRUITS-1:0] fruit_new;
  logic               fruit_any;
  logic               frightened;
  logic               kill;
  logic               fruit_take;
  logic [SUM_W-1:0]   add_pts;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic               move_key;
  logic               restart_key;

  // Sums carry one extra bit so boxes near the coordinate limit never wrap.
  function automatic logic overlap(input logic [COORD_W-1:0] ax, ay, as_, bx, by, bs);
    return ({1'b0, ax} < ({1'b0, bx} + {1'b0, bs})) &&
           ({1'b0, bx} < ({1'b0, ax} + {1'b0, as_})) &&
           ({1'b0, ay} < ({1'b0, by} + {1'b0, bs})) &&
           ({1'b0, by} < ({1'b0, ay} + {1'b0, as_}));
  endfunction

  assign move_key    = (keycode == 8'h04) || (keycode == 8'h07) ||
                       (keycode == 8'h16) || (keycode == 8'h1A);
  assign restart_key = (keycode == 8'h2C);

  always_comb begin
    ghost_hit = '0;
    fruit_new = '0;
    fruit_any = 1'b0;
    for (int i = 0; i < NUM_GHOSTS; i++)
      ghost_hit[i] = overlap(pX, pY, pSize, gX[i*COORD_W +: COORD_W], gY[i*COORD_W +: COORD_W], gSize);
    // Scan high to low so the lowest-index candidate is the one left selected.
    for (int i = NUM_FRUITS - 1; i >= 0; i--) begin
      if (!fruits[i] && overlap(pX, pY, pSize, fX[i*COORD_W +: COORD_W], fY[i*COORD_W +: COORD_W], fSize)) begin
        fruit_new    = '0;
        fruit_new[i] = 1'b1;
        fruit_any    = 1'b1;
      end
    end
  end

  assign kill       = (|ghost_hit) && !frightened;
  assign fruit_take = fruit_any && !kill;

  always_comb begin
    add_pts = fruit_take ? SUM_W'(FRUIT_PTS) : '0;
`ifdef POWER_FRUIT_EN
    for (int i = 0; i < NUM_GHOSTS; i++)
      if (frightened && ghost_hit[i]) add_pts = add_pts + SUM_W'(GHOST_PTS);
`endif
    score_sum  = SUM_W'(score) + add_pts;
    score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= PAUSE;
      score     <= '0;
      fruits    <= '0;
      lives     <= 3'(START_LIVES);
      respawn   <= 1'b0;
      death_cnt <= '0;
    end else begin
      respawn <= 1'b0;
      case (state)
        PAUSE: if (move_key) state <= RUN;
        RUN: if (frame_tick) begin
          if (kill) begin
            state     <= DEATH;
            lives     <= lives - 3'd1;
            death_cnt <= CNT_W'(DEATH_FRAMES);
          end else begin
            score <= score_next;
            if (fruit_take) begin
              fruits <= fruits | fruit_new;
              if (&(fruits | fruit_new)) state <= GAME_WON;
            end
          end
        end
        DEATH: if (frame_tick) begin
          if (death_cnt <= CNT_W'(1)) begin
            death_cnt <= '0;
            if (lives != 3'd0) begin
              state   <= PAUSE;
              respawn <= 1'b1;
            end else begin
              state <= GAME_OVER;
            end
          end else begin
            death_cnt <= death_cnt - CNT_W'(1);
          end
        end
        GAME_OVER, GAME_WON: if (restart_key) begin
          state   <= PAUSE;
          score   <= '0;
          fruits  <= '0;
          lives   <= 3'(START_LIVES);
          respawn <= 1'b1;
        end
        default: state <= PAUSE;
      endcase
    end
  end

`ifdef POWER_FRUIT_EN
  localparam int FR_W = (FRIGHT_FRAMES < 2) ? 1 : $clog2(FRIGHT_FRAMES + 1);
  logic [FR_W-1:0] fright_cnt;
  assign frightened = (fright_cnt != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fright_cnt  <= '0;
      ghost_eaten <= '0;
    end else begin
      ghost_eaten <= '0;
      if (state == RUN && frame_tick) begin
        if (frightened) ghost_eaten <= ghost_hit;
        if (fruit_take) fright_cnt <= FR_W'(FRIGHT_FRAMES);
        else if (frightened) fright_cnt <= fright_cnt - FR_W'(1);
      end else if (restart_key && (state == GAME_OVER || state == GAME_WON)) begin
        fright_cnt <= '0;
      end
    end
  end
`else
  assign frightened = 1'b0;
`endif

  assign win     = (state == GAME_WON);
  assign lose    = (state == GAME_OVER);
  assign running = (state == RUN);

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Randomized and directed bench for pacman_game_ctrl against a behavioural game model.
module tb_pacman_game_ctrl;
  localparam int NG = 3, NF = 4, CW = 10, SW = 12, FP = 50, SL = 3, DF = 60;
  localparam int S_PAUSE = 0, S_RUN = 1, S_DEATH = 2, S_OVER = 3, S_WON = 4;

  logic Clk = 1'b0;
  logic Reset, frame_tick;
  logic [7:0] keycode;
  logic [CW-1:0] pX, pY, pSize, gSize, fSize;
  logic [NG*CW-1:0] gX, gY;
  logic [NF*CW-1:0] fX, fY;
  logic win, lose, running, respawn;
  logic [NF-1:0] fruits;
  logic [SW-1:0] score;
  logic [2:0] lives;

  int n_vec = 0, n_err = 0;
  int m_state, m_score, m_lives, m_left;
  bit [NF-1:0] m_fruits;
  bit m_respawn;

  pacman_game_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .pX(pX), .pY(pY), .pSize(pSize), .gX(gX), .gY(gY), .gSize(gSize),
    .fX(fX), .fY(fY), .fSize(fSize), .win(win), .lose(lose), .running(running),
    .fruits(fruits), .score(score), .lives(lives), .respawn(respawn)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit boxes_hit(int ax, int ay, int as_, int bx, int by, int bs);
    return (ax < bx + bs) && (bx < ax + as_) && (ay < by + bs) && (by < ay + as_);
  endfunction

  // Game rules applied to the inputs present before the coming clock edge.
  task automatic model_step();
    bit ghost;
    int pick;
    m_respawn = 0;
    if (Reset) begin
      m_state = S_PAUSE; m_score = 0; m_fruits = '0; m_lives = SL;
      return;
    end
    case (m_state)
      S_PAUSE: if (keycode inside {8'h04, 8'h07, 8'h16, 8'h1A}) m_state = S_RUN;
      S_RUN: if (frame_tick) begin
        ghost = 0;
        for (int i = 0; i < NG; i++)
          if (boxes_hit(pX, pY, pSize, gX[i*CW +: CW], gY[i*CW +: CW], gSize)) ghost = 1;
        if (ghost) begin
          m_state = S_DEATH; m_lives--; m_left = DF;
        end else begin
          pick = -1;
          for (int i = 0; i < NF; i++)
            if (pick < 0 && !m_fruits[i] && boxes_hit(pX, pY, pSize, fX[i*CW +: CW], fY[i*CW +: CW], fSize))
              pick = i;
          if (pick >= 0) begin
            m_fruits[pick] = 1'b1;
            m_score = (m_score + FP > 4095) ? 4095 : m_score + FP;
            if (&m_fruits) m_state = S_WON;
          end
        end
      end
      S_DEATH: if (frame_tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_lives > 0) begin m_state = S_PAUSE; m_respawn = 1; end
          else m_state = S_OVER;
        end
      end
      default: if (keycode == 8'h2C) begin
        m_state = S_PAUSE; m_score = 0; m_fruits = '0; m_lives = SL; m_respawn = 1;
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    check("win", win, m_state == S_WON);
    check("lose", lose, m_state == S_OVER);
    check("running", running, m_state == S_RUN);
    check("fruits", fruits, m_fruits);
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("respawn", respawn, m_respawn);
  endtask

  task automatic park();
    for (int i = 0; i < NG; i++) begin gX[i*CW +: CW] = CW'(600 + 40*i); gY[i*CW +: CW] = 10'd600; end
    for (int i = 0; i < NF; i++) begin fX[i*CW +: CW] = CW'(800 + 40*i); fY[i*CW +: CW] = 10'd800; end
  endtask

  task automatic tick();
    frame_tick = 1; cycle(); frame_tick = 0;
  endtask

  task automatic go_run();
    keycode = 8'h1A; cycle(); keycode = 8'h00;
  endtask

  task automatic die_and_wait();
    gX[0 +: CW] = pX; gY[0 +: CW] = pY; tick();
    park();
    for (int i = 0; i < DF; i++) tick();
  endtask

  initial begin
    Reset = 1; frame_tick = 0; keycode = 0;
    pX = 0; pY = 0; pSize = 16; gSize = 16; fSize = 8;
    park();
    cycle(); cycle();
    check("reset_lives", lives, 3);
    check("reset_score", score, 0);
    Reset = 0;

    go_run();
    check("start_running", running, 1);
    check("start_fruits", fruits, 0);

    pX = 12; pY = 10; fX[0 +: CW] = 20; fY[0 +: CW] = 18;
    tick();
    check("fruit0_bit", fruits, 4'b0001);
    check("fruit0_score", score, 50);
    tick();
    check("fruit0_again", score, 50);

    park(); pX = 100; pY = 10; gX[0 +: CW] = 116; gY[0 +: CW] = 10;
    tick();
    check("edge_touch_alive", running, 1);
    gX[0 +: CW] = 115;
    tick();
    check("edge_overlap_lives", lives, 2);
    park();
    for (int i = 0; i < DF - 1; i++) tick();
    check("death_no_early_respawn", respawn, 0);
    tick();
    check("death_respawn", respawn, 1);

    go_run();
    fX[1*CW +: CW] = pX; fY[1*CW +: CW] = pY; gX[1*CW +: CW] = pX; gY[1*CW +: CW] = pY;
    tick();
    check("ghost_beats_fruit_bits", fruits, 4'b0001);
    check("ghost_beats_fruit_score", score, 50);
    park();
    for (int i = 0; i < DF; i++) tick();

    go_run();
    for (int i = 1; i < NF; i++) begin fX[i*CW +: CW] = pX; fY[i*CW +: CW] = pY; end
    tick(); tick();
    check("one_fruit_per_tick", fruits, 4'b0111);
    tick();
    check("win_fruits", fruits, 4'b1111);
    check("win_score", score, 200);
    check("win_flag", win, 1);
    park();
    keycode = 8'h2C; cycle(); keycode = 0;
    check("restart_score", score, 0);
    check("restart_respawn", respawn, 1);

    for (int k = 0; k < 3; k++) begin go_run(); die_and_wait(); end
    check("game_over", lose, 1);
    check("game_over_no_respawn", respawn, 0);
    keycode = 8'h2C; cycle(); keycode = 0;
    go_run();
    gX[0 +: CW] = pX; gY[0 +: CW] = pY; tick(); park();
    tick(); tick();
    Reset = 1; cycle(); Reset = 0;
    check("reset_in_death_lives", lives, 3);
    check("reset_in_death_running", running, 0);

    for (int n = 0; n < 4000; n++) begin
      bit edge_case;
      edge_case = ($urandom_range(0, 9) == 0);
      pX = edge_case ? CW'($urandom_range(1000, 1023)) : CW'($urandom_range(0, 60));
      pY = edge_case ? CW'($urandom_range(1000, 1023)) : CW'($urandom_range(0, 60));
      pSize = CW'($urandom_range(4, 20));
      gSize = CW'($urandom_range(4, 20));
      fSize = CW'($urandom_range(4, 20));
      for (int i = 0; i < NG; i++) begin
        gX[i*CW +: CW] = edge_case ? CW'($urandom_range(990, 1023)) : CW'($urandom_range(0, 400));
        gY[i*CW +: CW] = edge_case ? CW'($urandom_range(990, 1023)) : CW'($urandom_range(0, 400));
      end
      for (int i = 0; i < NF; i++) begin
        fX[i*CW +: CW] = CW'($urandom_range(0, 90));
        fY[i*CW +: CW] = CW'($urandom_range(0, 90));
      end
      case ($urandom_range(0, 7))
        0: keycode = 8'h04;
        1: keycode = 8'h07;
        2: keycode = 8'h16;
        3: keycode = 8'h1A;
        4: keycode = 8'h2C;
        5: keycode = 8'($urandom);
        default: keycode = 8'h00;
      endcase
      frame_tick = ($urandom_range(0, 9) < 5);
      Reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    Reset = 0; frame_tick = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
